set_assoc_icache: RTL and testbench

SET_ASSOC_ICACHE -- requirements
Module: set_assoc_icache

---
 rtl/icache_pkg.sv | 32 +++
 rtl/icache_refill_buf.sv | 55 +++++
 rtl/set_assoc_icache.sv | 229 ++++++++++++++++++++++
 tb/tb_set_assoc_icache.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared state encoding, AXI constants and derived-width helpers for the set-associative I-cache.
package icache_pkg;

    typedef logic [2:0] icache_state_t;

    localparam icache_state_t ST_IDLE     = 3'd0;
    localparam icache_state_t ST_LOOKUP   = 3'd1;
    localparam icache_state_t ST_MISS_REQ = 3'd2;
    localparam icache_state_t ST_REFILL   = 3'd3;
    localparam icache_state_t ST_RESPOND  = 3'd4;
    localparam icache_state_t ST_FLUSH    = 3'd5;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic int offset_bits(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int addr_w, input int sets, input int line_bytes);
        return addr_w - $clog2(sets) - $clog2(line_bytes);
    endfunction

    function automatic int beat_count(input int line_bytes, input int axi_data_w);
        return line_bytes / (axi_data_w / 8);
    endfunction

endpackage

// File: rtl/icache_refill_buf.sv
// Collects AXI read beats into a line buffer and flags rresp errors or a wrong beat count at rlast.
module icache_refill_buf
    import icache_pkg::*;
#(
    parameter int AXI_DATA_W = 64,
    parameter int LINE_BYTES = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    beat_valid,
    input  logic [AXI_DATA_W-1:0]   beat_data,
    input  logic [1:0]              beat_resp,
    input  logic                    beat_last,
    input  logic [7:0]              exp_len,
    output logic [LINE_BYTES*8-1:0] line,
    output logic                    err
);

    localparam int BEATS = beat_count(LINE_BYTES, AXI_DATA_W);

    // One bit wider than arlen so runaway bursts saturate instead of wrapping onto a valid count.
    logic [8:0] beat_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            beat_cnt <= '0;
            err      <= 1'b0;
        end else if (start) begin
            beat_cnt <= '0;
            err      <= 1'b0;
        end else if (beat_valid) begin
            if (beat_resp != AXI_RESP_OKAY) begin
                err <= 1'b1;
            end
            if (beat_last && (beat_cnt != {1'b0, exp_len})) begin
                err <= 1'b1;
            end
            if (beat_cnt != 9'h1FF) begin
                beat_cnt <= beat_cnt + 9'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (beat_valid) begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat_cnt == 9'(b)) begin
                    line[b*AXI_DATA_W +: AXI_DATA_W] <= beat_data;
                end
            end
        end
    end

endmodule

// File: rtl/set_assoc_icache.sv
// Blocking set-associative instruction cache with AXI line refill and round-robin replacement.
// Build option ICACHE_PERF_CNT_EN adds saturating hit/miss counters; otherwise they read 0.
//
// state     | meaning
// IDLE      | ready for a request unless a flush is pending
// LOOKUP    | tag compare; hit responds this cycle
// MISS_REQ  | AR channel held valid until accepted
// REFILL    | collecting beats into the refill buffer
// RESPOND   | install line (if clean) and answer the request
// FLUSH     | clear valid bits and replacement pointers
module set_assoc_icache
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int WAYS       = 4,
    parameter int SETS       = 4,
    parameter int LINE_BYTES = 64,
    parameter int AXI_DATA_W = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  flush,
    output logic                  resp_valid,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [AXI_DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int OFF_W  = offset_bits(LINE_BYTES);
    localparam int IDX_W  = index_bits(SETS);
    localparam int TAG_W  = tag_bits(ADDR_W, SETS, LINE_BYTES);
    localparam int BEATS  = beat_count(LINE_BYTES, AXI_DATA_W);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    icache_state_t     state;
    logic [ADDR_W-1:0] addr_q;
    logic              flush_pend;

    logic [TAG_W-1:0]  tag_arr   [SETS][WAYS];
    logic [LINE_W-1:0] data_arr  [SETS][WAYS];
    logic [WAYS-1:0]   valid_arr [SETS];
    logic [PTR_W-1:0]  rr_ptr    [SETS];

    logic [IDX_W-1:0]  idx_q;
    logic [TAG_W-1:0]  tag_q;
    logic [OFF_W+2:0]  bit_sel;
    logic              unused_addr_lsbs;

    assign idx_q            = addr_q[OFF_W +: IDX_W];
    assign tag_q            = addr_q[ADDR_W-1 -: TAG_W];
    assign bit_sel          = {addr_q[OFF_W-1:2], 5'd0};
    assign unused_addr_lsbs = ^addr_q[1:0];

    logic              hit;
    logic [PTR_W-1:0]  hit_way;
    logic [PTR_W-1:0]  victim;
    logic              use_rr;
    logic [PTR_W-1:0]  rr_next;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_arr[idx_q][w] && (tag_arr[idx_q][w] == tag_q)) begin
                hit     = 1'b1;
                hit_way = PTR_W'(w);
            end
        end
    end

    // First invalid way wins; the round-robin pointer only moves when it actually picked the victim.
    always_comb begin
        use_rr = 1'b1;
        victim = rr_ptr[idx_q];
        for (int w = 0; w < WAYS; w++) begin
            if (use_rr && !valid_arr[idx_q][w]) begin
                use_rr = 1'b0;
                victim = PTR_W'(w);
            end
        end
    end

    assign rr_next = (rr_ptr[idx_q] == PTR_W'(WAYS - 1)) ? '0 : rr_ptr[idx_q] + PTR_W'(1);

    logic [LINE_W-1:0] refill_line;
    logic              refill_err;
    logic              refill_start;
    logic              refill_beat;
    logic              install;
    logic              lookup_hit;
    logic              accept;

    assign accept       = req_valid && req_ready;
    assign refill_start = (state == ST_MISS_REQ) && m_axi_arready;
    assign refill_beat  = (state == ST_REFILL) && m_axi_rvalid;
    assign install      = (state == ST_RESPOND) && !refill_err;
    assign lookup_hit   = (state == ST_LOOKUP) && hit;

    icache_refill_buf #(
        .AXI_DATA_W (AXI_DATA_W),
        .LINE_BYTES (LINE_BYTES)
    ) u_refill_buf (
        .clock      (clock),
        .reset      (reset),
        .start      (refill_start),
        .beat_valid (refill_beat),
        .beat_data  (m_axi_rdata),
        .beat_resp  (m_axi_rresp),
        .beat_last  (m_axi_rlast),
        .exp_len    (m_axi_arlen),
        .line       (refill_line),
        .err        (refill_err)
    );

    assign req_ready     = (state == ST_IDLE) && !flush_pend && !flush;
    assign m_axi_arvalid = (state == ST_MISS_REQ);
    assign m_axi_araddr  = m_axi_arvalid ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign m_axi_arlen   = 8'(BEATS - 1);
    assign m_axi_arsize  = 3'($clog2(AXI_DATA_W / 8));
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_rready  = (state == ST_REFILL);
    assign resp_valid    = lookup_hit || (state == ST_RESPOND);
    assign resp_err      = (state == ST_RESPOND) && refill_err;
    assign resp_data     = lookup_hit ? data_arr[idx_q][hit_way][bit_sel +: 32] :
                           install    ? refill_line[bit_sel +: 32] : 32'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            addr_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flush || flush_pend) begin
                        state <= ST_FLUSH;
                    end else if (accept) begin
                        addr_q <= req_addr;
                        state  <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP:   state <= hit ? ST_IDLE : ST_MISS_REQ;
                ST_MISS_REQ: if (m_axi_arready) state <= ST_REFILL;
                ST_REFILL:   if (m_axi_rvalid && m_axi_rlast) state <= ST_RESPOND;
                ST_RESPOND:  state <= ST_IDLE;
                ST_FLUSH:    state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    // A flush seen mid-transaction is held until the FSM is back in IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush_pend <= 1'b0;
        end else if (state == ST_FLUSH) begin
            flush_pend <= 1'b0;
        end else if (flush && (state != ST_IDLE)) begin
            flush_pend <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                rr_ptr[s]    <= '0;
            end
        end else if (state == ST_FLUSH) begin
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                rr_ptr[s]    <= '0;
            end
        end else if (install) begin
            valid_arr[idx_q][victim] <= 1'b1;
            if (use_rr) begin
                rr_ptr[idx_q] <= rr_next;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (install) begin
            tag_arr[idx_q][victim]  <= tag_q;
            data_arr[idx_q][victim] <= refill_line;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state == ST_LOOKUP) begin
            if (hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (!hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_set_assoc_icache.sv
// Randomized bench for set_assoc_icache against a way/tag reference model and an AXI memory model.
module tb_set_assoc_icache;

`ifdef ICACHE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        flush;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    set_assoc_icache #(
        .ADDR_W     (64),
        .WAYS       (4),
        .SETS       (4),
        .LINE_BYTES (64),
        .AXI_DATA_W (64)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .flush         (flush),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: resident tag per (set, way), replacement pointer per set, event counts.
    logic [63:0] m_tag [4][4];
    bit          m_val [4][4];
    int          m_rr  [4];
    int unsigned m_hits;
    int unsigned m_misses;

    function automatic int m_way(input logic [63:0] a);
        int s = int'(a[7:6]);
        for (int w = 0; w < 4; w++) begin
            if (m_val[s][w] && m_tag[s][w] == (a >> 8)) return w;
        end
        return -1;
    endfunction

    function automatic void m_install(input logic [63:0] a);
        int s = int'(a[7:6]);
        int v = -1;
        for (int w = 0; w < 4; w++) begin
            if (v < 0 && !m_val[s][w]) v = w;
        end
        if (v < 0) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % 4;
        end
        m_val[s][v] = 1'b1;
        m_tag[s][v] = a >> 8;
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < 4; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 4; w++) m_val[s][w] = 1'b0;
        end
    endfunction

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [63:0] beat_data(input logic [63:0] line_a, input int b);
        logic [63:0] base = line_a + 64'(8 * b);
        return {mem_word(base + 64'd4), mem_word(base)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hits"}, 64'(hit_count), PERF ? 64'(m_hits) : 64'd0);
        check({tag, "_misses"}, 64'(miss_count), PERF ? 64'(m_misses) : 64'd0);
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!req_ready && guard < 10) begin
            tick();
            guard++;
        end
        check("req_ready", 64'(req_ready), 64'd1);
    endtask

    task automatic do_read(input logic [63:0] a, input int err_beat, input int flush_beat,
                           input int rst_beat, output bit obs_miss);
        bit          exp_hit;
        bit          err_exp;
        int          guard;
        logic [63:0] line_a;
        line_a   = a & ~64'h3F;
        obs_miss = 1'b0;
        wait_ready();
        exp_hit   = (m_way(a) >= 0);
        req_valid = 1'b1;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
        check("resp_at_lookup", 64'(resp_valid), 64'(exp_hit));
        check("no_ar_at_lookup", 64'(m_axi_arvalid), 64'd0);
        obs_miss = !resp_valid;
        if (resp_valid) begin
            check("hit_data", 64'(resp_data), 64'(mem_word(a & ~64'h3)));
            check("hit_err", 64'(resp_err), 64'd0);
            if (exp_hit) m_hits++;
            tick();
            return;
        end
        if (!exp_hit) m_misses++;
        tick();
        guard = 0;
        while (!m_axi_arvalid && guard < 8) begin
            tick();
            guard++;
        end
        check("arvalid", 64'(m_axi_arvalid), 64'd1);
        if (!m_axi_arvalid) return;
        check("araddr", m_axi_araddr, line_a);
        check("arlen", 64'(m_axi_arlen), 64'd7);
        check("arsize", 64'(m_axi_arsize), 64'd3);
        check("arburst", 64'(m_axi_arburst), 64'd1);
        repeat ($urandom_range(0, 2)) begin
            tick();
            check("arvalid_hold", 64'(m_axi_arvalid), 64'd1);
        end
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        err_exp = 1'b0;
        for (int b = 0; b < 8; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            if (b == rst_beat) begin
                reset        = 1'b0;
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                #1;
                check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
                check("rst_rready", 64'(m_axi_rready), 64'd0);
                check("rst_resp_valid", 64'(resp_valid), 64'd0);
                check("rst_hit_count", 64'(hit_count), 64'd0);
                check("rst_miss_count", 64'(miss_count), 64'd0);
                m_clear();
                m_hits   = 0;
                m_misses = 0;
                tick();
                tick();
                reset = 1'b1;
                tick();
                return;
            end
            check("rready", 64'(m_axi_rready), 64'd1);
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = beat_data(line_a, b);
            m_axi_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            m_axi_rlast  = (b == 7);
            flush        = (b == flush_beat);
            if (b == err_beat) err_exp = 1'b1;
            tick();
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
            m_axi_rresp  = 2'b00;
            flush        = 1'b0;
        end
        check("resp_valid", 64'(resp_valid), 64'd1);
        check("resp_err", 64'(resp_err), 64'(err_exp));
        check("resp_data", 64'(resp_data), err_exp ? 64'd0 : 64'(mem_word(a & ~64'h3)));
        if (!err_exp) m_install(a);
        if (flush_beat >= 0 && flush_beat < 8) m_clear();
        tick();
    endtask

    // Flush raised together with a request in IDLE: the flush must win and the request be refused.
    task automatic idle_flush(input logic [63:0] a);
        wait_ready();
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        check("ready_during_flush", 64'(req_ready), 64'd0);
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_no_resp", 64'(resp_valid), 64'd0);
        check("flush_state_not_ready", 64'(req_ready), 64'd0);
        m_clear();
        tick();
    endtask

    initial begin
        bit          om;
        logic [63:0] a;
        int          eb;
        int          fb;

        reset         = 1'b0;
        req_valid     = 1'b0;
        req_addr      = '0;
        flush         = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        m_clear();
        m_hits   = 0;
        m_misses = 0;

        tick();
        tick();
        check("reset_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("reset_rready", 64'(m_axi_rready), 64'd0);
        check("reset_resp_valid", 64'(resp_valid), 64'd0);
        check("reset_resp_err", 64'(resp_err), 64'd0);
        check("reset_resp_data", 64'(resp_data), 64'd0);
        check("reset_araddr", m_axi_araddr, 64'd0);
        check_counters("reset");
        reset = 1'b1;
        tick();
        check("idle_ready", 64'(req_ready), 64'd1);

        do_read(64'h1008, -1, -1, -1, om);
        check("cold_read_miss", 64'(om), 64'd1);
        check_counters("cold");
        do_read(64'h100C, -1, -1, -1, om);
        check("warm_read_hit", 64'(om), 64'd0);
        check_counters("warm");

        do_read(64'h1000, -1, -1, -1, om);
        do_read(64'h2000, -1, -1, -1, om);
        do_read(64'h3000, -1, -1, -1, om);
        do_read(64'h4000, -1, -1, -1, om);
        do_read(64'h5000, -1, -1, -1, om);
        check("evict_newline_miss", 64'(om), 64'd1);
        do_read(64'h1000, -1, -1, -1, om);
        check("evicted_way0_miss", 64'(om), 64'd1);
        do_read(64'h4004, -1, -1, -1, om);
        check("survivor_hit", 64'(om), 64'd0);
        check_counters("evict");

        do_read(64'h7040, 3, -1, -1, om);
        do_read(64'h7040, -1, -1, -1, om);
        check("err_reread_miss", 64'(om), 64'd1);
        do_read(64'h7044, -1, -1, -1, om);
        check("err_clean_hit", 64'(om), 64'd0);

        do_read(64'h8080, -1, 2, -1, om);
        do_read(64'h8080, -1, -1, -1, om);
        check("flush_refill_miss", 64'(om), 64'd1);
        idle_flush(64'h8084);
        do_read(64'h8084, -1, -1, -1, om);
        check("idle_flush_miss", 64'(om), 64'd1);
        check_counters("flush");

        for (int i = 0; i < 120; i++) begin
            a = ((64'($urandom_range(0, 5)) + 64'h40) << 8)
              | (64'($urandom_range(0, 3)) << 6)
              | (64'($urandom_range(0, 15)) << 2);
            eb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
            fb = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 7)) : -1;
            if ($urandom_range(0, 14) == 0) idle_flush(a);
            do_read(a, eb, fb, -1, om);
        end
        check_counters("random");

        do_read(64'h9100, -1, -1, 4, om);
        do_read(64'h9100, -1, -1, -1, om);
        check("post_reset_miss", 64'(om), 64'd1);
        check_counters("post_reset");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
